// File: rtl/bp_table_ctrl_pkg.sv
// Shared types for the 2-bit branch-counter table controller.
// Optional feature macro: BP_UPD_BYPASS_EN (used by bp_table_ctrl / bp_update_fifo).
package bp_table_ctrl_pkg;

    localparam int BP_IDX_W = 4;

    typedef logic [1:0] bp_count_t;
    localparam bp_count_t BP_WEAK_TAKEN = 2'b10;

    // One resolved branch outcome waiting to be folded into the table.
    typedef struct packed {
        logic [BP_IDX_W-1:0] index;
        logic                taken;
    } bp_upd_t;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } bp_ctrl_state_t;

    // Saturating 2-bit counter step: taken counts up to 2'b11, not-taken down to 2'b00.
    function automatic bp_count_t sat(input bp_count_t cnt, input logic taken);
        bp_count_t res;
        res = cnt;
        if (taken) begin
            if (cnt != 2'b11) res = cnt + 2'b01;
        end else begin
            if (cnt != 2'b00) res = cnt - 2'b01;
        end
        return res;
    endfunction

endpackage

// File: rtl/bp_table_ctrl_if.sv
// Fetch-lookup and execute-update channels of the branch-counter table controller.
// Handshakes: an update transfers on a rising edge where upd_valid && upd_ready;
// a lookup is served in the cycle where lookup_req && lookup_gnt (lookup_count valid then).
interface bp_table_ctrl_if
    import bp_table_ctrl_pkg::*;
#(
    parameter int IDX_W = BP_IDX_W
);
    logic             lookup_req;
    logic [IDX_W-1:0] lookup_index;
    logic             lookup_gnt;
    bp_count_t        lookup_count;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             upd_ready;

    // Fetch / execute side.
    modport master (
        output lookup_req, lookup_index, upd_valid, upd_index, upd_taken,
        input  lookup_gnt, lookup_count, upd_ready
    );

    // Controller side.
    modport slave (
        input  lookup_req, lookup_index, upd_valid, upd_index, upd_taken,
        output lookup_gnt, lookup_count, upd_ready
    );
endinterface

// File: rtl/bp_table_ctrl_update_fifo.sv
// bp_update_fifo: circular queue of pending counter updates.
// With BP_UPD_BYPASS_EN the storage, read pointer and fill level are exported
// so the controller can fold pending updates into a lookup.
module bp_update_fifo
    import bp_table_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    clear,
    input  logic    push,
    input  bp_upd_t push_data,
    input  logic    pop,
    output bp_upd_t head,
    output logic    full,
    output logic    empty
`ifdef BP_UPD_BYPASS_EN
    ,
    output bp_upd_t                  entries [DEPTH],
    output logic [$clog2(DEPTH)-1:0] rd_ptr,
    output logic [$clog2(DEPTH):0]   count
`endif
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    bp_upd_t          mem_q [DEPTH];
    bp_upd_t          mem_d [DEPTH];
    logic             push_ok, pop_ok;

    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

`ifdef BP_UPD_BYPASS_EN
    assign entries = mem_q;
    assign rd_ptr  = rd_ptr_q;
    assign count   = count_q;
`endif

    // Queue storage and pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    // Push/pop bookkeeping; clear drops every pending entry.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

endmodule

// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: sequences the single-port 2-bit branch-counter table.
// Walks the table to weakly-taken after reset/flush, then arbitrates each cycle
// between a fetch lookup and the oldest queued update (read-modify-write).
// An update that has lost STARVE_LIM arbitrations in a row is forced ahead.
// Optional macro BP_UPD_BYPASS_EN: lookups see pending queued updates to their index.
module bp_table_ctrl
    import bp_table_ctrl_pkg::*;
#(
    parameter int IDX_W      = BP_IDX_W,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    output logic              busy,
    bp_table_ctrl_if.slave    bus,
    output logic [IDX_W-1:0]  tbl_index,
    input  bp_count_t         tbl_rdata,
    output logic              tbl_we,
    output bp_count_t         tbl_wdata
);
    localparam int SW    = $clog2(STARVE_LIM + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    bp_ctrl_state_t   state_q, state_d;
    logic [IDX_W-1:0] walk_q, walk_d;
    logic [SW-1:0]    starve_q, starve_d;

    bp_upd_t   head;
    logic      full, empty, push, pop;
    logic      force_upd, lookup_win;
    bp_count_t byp_count;

    assign force_upd     = (starve_q == SW'(STARVE_LIM)) && !empty;
    assign lookup_win    = (state_q == S_RUN) && bus.lookup_req && !force_upd;
    assign bus.upd_ready = !full && !busy;
    assign push          = bus.upd_valid && bus.upd_ready;

`ifdef BP_UPD_BYPASS_EN
    bp_upd_t          q_entries [FIFO_DEPTH];
    logic [PTR_W-1:0] q_rd_ptr;
    logic [PTR_W:0]   q_count;
`endif

    bp_update_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (push),
        .push_data ('{index: bus.upd_index, taken: bus.upd_taken}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
`ifdef BP_UPD_BYPASS_EN
        ,
        .entries   (q_entries),
        .rd_ptr    (q_rd_ptr),
        .count     (q_count)
`endif
    );

`ifdef BP_UPD_BYPASS_EN
    // Advance the table value through every pending update to the looked-up index, oldest first.
    always_comb begin
        logic [PTR_W-1:0] slot;
        byp_count = tbl_rdata;
        slot      = q_rd_ptr;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (((PTR_W+1)'(i) < q_count) && (q_entries[slot].index == bus.lookup_index))
                byp_count = sat(byp_count, q_entries[slot].taken);
            slot = slot + PTR_W'(1);
        end
    end
`else
    assign byp_count = tbl_rdata;
`endif

    // State register: FSM state, init walk pointer, starvation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_INIT;
            walk_q   <= '0;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            walk_q   <= walk_d;
            starve_q <= starve_d;
        end
    end

    // Next state: walk one entry per cycle; flush restarts the walk from entry 0.
    always_comb begin
        state_d  = state_q;
        walk_d   = walk_q;
        starve_d = starve_q;
        case (state_q)
            S_INIT: begin
                starve_d = '0;
                if (flush) begin
                    walk_d = '0;
                end else begin
                    walk_d = walk_q + IDX_W'(1);
                    if (walk_q == {IDX_W{1'b1}}) state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Any pop (or an empty queue) clears the count; a won lookup against a waiting update bumps it.
                if (empty || !lookup_win)            starve_d = '0;
                else if (starve_q != SW'(STARVE_LIM)) starve_d = starve_q + SW'(1);
                if (flush) begin
                    state_d = S_INIT;
                    walk_d  = '0;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Outputs: table port steering, lookup grant, update pop.
    always_comb begin
        busy             = 1'b1;
        bus.lookup_gnt   = 1'b0;
        bus.lookup_count = byp_count;
        tbl_index        = walk_q;
        tbl_we           = 1'b0;
        tbl_wdata        = BP_WEAK_TAKEN;
        pop              = 1'b0;
        case (state_q)
            S_INIT: begin
                // No array write while reset is held.
                tbl_we = rst_n;
            end
            S_RUN: begin
                busy = 1'b0;
                if (lookup_win) begin
                    bus.lookup_gnt = 1'b1;
                    tbl_index      = bus.lookup_index;
                end else if (!empty) begin
                    tbl_index = head.index;
                    tbl_we    = 1'b1;
                    tbl_wdata = sat(tbl_rdata, head.taken);
                    pop       = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Testbench for bp_table_ctrl: directed vectors, a cycle-level behavioural model
// compared on every negedge, and literal write/lookup expectations.
`timescale 1ns/1ps
module tb_bp_table_ctrl;
    import bp_table_ctrl_pkg::*;

    localparam int IDX_W      = 4;
    localparam int DEPTH      = 16;
    localparam int FIFO_DEPTH = 4;
    localparam int STARVE_LIM = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    logic [IDX_W-1:0] tbl_index;
    bp_count_t        tbl_rdata, tbl_wdata;
    logic             tbl_we;

    bp_table_ctrl_if #(.IDX_W(IDX_W)) bus();

    bp_table_ctrl #(
        .IDX_W(IDX_W), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIM(STARVE_LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy), .bus(bus),
        .tbl_index(tbl_index), .tbl_rdata(tbl_rdata), .tbl_we(tbl_we), .tbl_wdata(tbl_wdata)
    );

    // Counter array: combinational read, write on the clock edge.
    bp_count_t mem [DEPTH];
    assign tbl_rdata = mem[tbl_index];
    always @(posedge clk) if (tbl_we) mem[tbl_index] <= tbl_wdata;

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [5:0] exp_q [$];   // expected run-time writes {index, wdata}, in order

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !busy && tbl_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: got write idx %0d data %0d, expected none at %0t",
                         tbl_index, tbl_wdata, $time);
            end else begin
                chk("wr_seq", {tbl_index, tbl_wdata}, exp_q.pop_front());
            end
        end
    end

    // ---------------- behavioural model ----------------
    bit        m_busy;
    int        m_walk;
    int        m_starve;
    int        m_tbl [DEPTH];
    bp_upd_t   m_q [$];
    bp_upd_t   m_h;
    bit        m_win, m_acc, m_force;
    int        m_v;

    function automatic int m_sat(input int v, input bit t);
        if (t) return (v >= 3) ? 3 : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            m_busy = 1'b1; m_walk = 0; m_starve = 0; m_q.delete();
            chk("rst_busy", busy, 1);
            chk("rst_gnt", bus.lookup_gnt, 0);
            chk("rst_we", tbl_we, 0);
            chk("rst_ready", bus.upd_ready, 0);
        end else if (m_busy) begin
            chk("m_init_busy", busy, 1);
            chk("m_init_gnt", bus.lookup_gnt, 0);
            chk("m_init_ready", bus.upd_ready, 0);
            chk("m_init_we", tbl_we, 1);
            chk("m_init_idx", tbl_index, m_walk);
            chk("m_init_wdata", tbl_wdata, 2);
            m_tbl[m_walk] = 2;
            if (flush)                m_walk = 0;
            else if (m_walk == DEPTH-1) m_busy = 1'b0;
            else                      m_walk++;
        end else begin
            m_force = (m_starve == STARVE_LIM) && (m_q.size() > 0);
            m_win   = bus.lookup_req && !m_force;
            m_acc   = bus.upd_valid && (m_q.size() < FIFO_DEPTH);
            chk("m_busy", busy, 0);
            chk("m_gnt", bus.lookup_gnt, m_win);
            chk("m_ready", bus.upd_ready, m_q.size() < FIFO_DEPTH);
            if (m_win) begin
                m_v = m_tbl[bus.lookup_index];
`ifdef BP_UPD_BYPASS_EN
                foreach (m_q[k]) if (m_q[k].index == bus.lookup_index) m_v = m_sat(m_v, m_q[k].taken);
`endif
                chk("m_lk_we", tbl_we, 0);
                chk("m_lk_idx", tbl_index, bus.lookup_index);
                chk("m_lk_count", bus.lookup_count, m_v);
                if (m_q.size() == 0)           m_starve = 0;
                else if (m_starve < STARVE_LIM) m_starve++;
            end else if (m_q.size() > 0) begin
                m_h = m_q.pop_front();
                m_v = m_sat(m_tbl[m_h.index], m_h.taken);
                chk("m_upd_we", tbl_we, 1);
                chk("m_upd_idx", tbl_index, m_h.index);
                chk("m_upd_wdata", tbl_wdata, m_v);
                m_tbl[m_h.index] = m_v;
                m_starve = 0;
            end else begin
                chk("m_idle_we", tbl_we, 0);
                m_starve = 0;
            end
            if (m_acc) m_q.push_back('{index: bus.upd_index, taken: bus.upd_taken});
            if (flush) begin
                m_busy = 1'b1; m_walk = 0; m_starve = 0; m_q.delete();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push_upd(input int idx, input bit t);
        bit r;
        bit ok;
        ok = 1'b0;
        bus.upd_valid = 1'b1; bus.upd_index = IDX_W'(idx); bus.upd_taken = t;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk); r = bus.upd_ready;
            @(posedge clk); #1; ok = r;
        end
        bus.upd_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic lookup_chk(input int idx, input int exp, input string name);
        bus.lookup_req = 1'b1; bus.lookup_index = IDX_W'(idx);
        @(negedge clk);
        chk({name, "_gnt"}, bus.lookup_gnt, 1);
        chk({name, "_count"}, bus.lookup_count, exp);
        @(posedge clk); #1;
        bus.lookup_req = 1'b0;
    endtask

    // Count busy cycles of a walk and pin its addresses/data literally.
    task automatic walk_check(input string name);
        int  n;
        bit  done;
        n = 0; done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (busy) begin
                chk({name, "_idx"}, tbl_index, n);
                chk({name, "_wdata"}, tbl_wdata, 2);
                n++;
            end else begin
                done = 1'b1;
            end
        end
        chk({name, "_cycles"}, n, 16);
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] gnt_hist;
    logic [5:0] rdy_hist;

    initial begin
        int k, c;
        bit r;
        bus.lookup_req = 1'b0; bus.lookup_index = '0;
        bus.upd_valid = 1'b0; bus.upd_index = '0; bus.upd_taken = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset release: 16-cycle walk writing 2'b10 to 0..15.
        walk_check("init");
        step();

        // Taken x3 on idx 5: 10 -> 11, then saturate.
        repeat (3) exp_q.push_back({4'd5, 2'b11});
        repeat (3) push_upd(5, 1'b1);
        repeat (3) step();
        chk("t2_drain", exp_q.size(), 0);
        lookup_chk(5, 3, "t2_lookup");

        // Not-taken x4 on idx 2: 01, 00, 00, 00 (no wrap).
        exp_q.push_back({4'd2, 2'b01});
        repeat (3) exp_q.push_back({4'd2, 2'b00});
        repeat (4) push_upd(2, 1'b0);
        repeat (3) step();
        chk("t3_drain", exp_q.size(), 0);
        lookup_chk(2, 0, "t3_lookup");

        // Starvation: lookup held, one update waits 3 wins then is forced.
        bus.lookup_req = 1'b1; bus.lookup_index = 4'd0;
        exp_q.push_back({4'd9, 2'b11});
        push_upd(9, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); gnt_hist[i] = bus.lookup_gnt;
            @(posedge clk); #1;
        end
        chk("t4_gnt_seq", gnt_hist, 4'b0111);
        chk("t4_drain", exp_q.size(), 0);

        // Fill queue with lookups hogging: ready drops at full, 5th waits for the forced pop.
        for (int i = 10; i < 15; i++) exp_q.push_back({4'(i), 2'b11});
        bus.upd_valid = 1'b1; k = 0; c = 0; rdy_hist = '0;
        while (k < 5 && c < 30) begin
            bus.upd_index = IDX_W'(10 + k); bus.upd_taken = 1'b1;
            @(negedge clk); r = bus.upd_ready;
            if (c < 6) rdy_hist[c] = r;
            @(posedge clk); #1;
            if (r) k++;
            c++;
        end
        bus.upd_valid = 1'b0;
        chk("t5_ready_seq", rdy_hist, 6'b101111);
        chk("t5_pushes", k, 5);
        bus.lookup_req = 1'b0;
        repeat (8) step();
        chk("t5_drain", exp_q.size(), 0);

        // Flush with two updates pending: they are dropped, table re-walked.
        bus.lookup_req = 1'b1; bus.lookup_index = 4'd0;
        push_upd(3, 1'b0);
        push_upd(4, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        chk("t6_flush_gnt", bus.lookup_gnt, 1);
        @(posedge clk); #1;
        flush = 1'b0; bus.lookup_req = 1'b0;
        walk_check("flush");
        step();
        for (int i = 0; i < DEPTH; i++) lookup_chk(i, 2, "t6_post_flush");
        chk("t6_no_writes", exp_q.size(), 0);

        // Lookup of idx 7 (table 01) with taken,taken still queued on 7.
        exp_q.push_back({4'd7, 2'b01});
        push_upd(7, 1'b0);
        repeat (2) step();
        chk("t7_setup_drain", exp_q.size(), 0);
        bus.lookup_req = 1'b1; bus.lookup_index = 4'd0;
        exp_q.push_back({4'd7, 2'b10});
        exp_q.push_back({4'd7, 2'b11});
        push_upd(7, 1'b1);
        push_upd(7, 1'b1);
        bus.lookup_index = 4'd7;
        @(negedge clk);
        chk("t7_gnt", bus.lookup_gnt, 1);
`ifdef BP_UPD_BYPASS_EN
        chk("t7_bypass_count", bus.lookup_count, 3);
`else
        chk("t7_stale_count", bus.lookup_count, 1);
`endif
        @(posedge clk); #1;
        bus.lookup_req = 1'b0;
        repeat (4) step();
        chk("t7_drain", exp_q.size(), 0);
        lookup_chk(7, 3, "t7_final");

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
